// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;
    localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

    localparam logic [UART_DATA_BITS-1:0] HDR_BASE_DEFAULT = 8'hA0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HDR_WAIT,
        ST_DATA,
        ST_DATA_WAIT
    } arb_state_t;

    // Header byte wraps modulo 256 by construction of the 8-bit add.
    function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [7:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin selector starting at ptr
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any && req[IW'(j)]) begin
                any          = 1'b1;
                gnt[IW'(j)]  = 1'b1;
                idx          = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one UART byte transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT,
    parameter int         MAX_LEN  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   overflow
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    arb_state_t           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        r_rr_ptr;
    logic [7:0]           r_len;
    logic                 r_last;
    logic [7:0]           r_tx_data;
    logic                 r_overflow;

    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_pick_any;
    logic                 w_src_valid;
    logic [7:0]           w_src_data;
    logic                 w_src_last;
    logic                 w_data_fire;
    logic                 w_len_max;
    logic [IW-1:0]        w_next_ptr;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_picker (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // The one-hot grant drives the source mux so only the owner is ever observed.
    always_comb begin
        w_src_valid = 1'b0;
        w_src_data  = '0;
        w_src_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_src_valid = req_valid[i];
                w_src_data  = req_data[8*i +: 8];
                w_src_last  = req_last[i];
            end
        end
    end

    assign w_data_fire = (r_state == ST_DATA) && w_src_valid;
    assign w_len_max   = (r_len == LEN_MAX);
    assign w_next_ptr  = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

    // Data bytes hand-shake in the same cycle they are presented, so ready and
    // start are decoded from the registered state plus the owner's valid.
    assign req_ready = w_data_fire ? r_grant : '0;
    assign tx_start  = (r_state == ST_HDR) || w_data_fire;
    assign tx_data   = w_data_fire ? w_src_data : r_tx_data;
    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign overflow  = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_idx      <= '0;
            r_rr_ptr   <= '0;
            r_len      <= '0;
            r_last     <= 1'b0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_grant   <= w_pick_gnt;
                        r_idx     <= w_pick_idx;
                        r_tx_data <= hdr_byte(HDR_BASE, 8'(w_pick_idx));
                        r_state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    r_state <= ST_HDR_WAIT;
                end
                ST_HDR_WAIT: begin
                    if (tx_done) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_src_valid) begin
                        r_tx_data <= w_src_data;
                        r_last    <= w_src_last;
                        r_len     <= r_len + 8'd1;
                        r_state   <= ST_DATA_WAIT;
                    end
                end
                ST_DATA_WAIT: begin
                    if (tx_done) begin
                        if (r_last || w_len_max) begin
                            if (!r_last) begin
                                r_overflow <= 1'b1;
                            end
                            r_grant  <= '0;
                            r_len    <= '0;
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NR     = 4;
    localparam int TX_LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data  = '0;
    logic [NR-1:0]   req_last  = '0;
    logic [NR-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_done = 1'b0;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            overflow;

    uart_tx_arbiter #(
        .NUM_REQ  (NR),
        .HDR_BASE (8'hA0),
        .MAX_LEN  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .grant     (grant),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src_b [NR][16];
    logic       src_l [NR][16];
    int         src_len [NR] = '{0, 0, 0, 0};
    int         src_ptr [NR] = '{0, 0, 0, 0};
    logic [NR-1:0] src_en = '0;
    bit         stall_on = 1'b0;
    int         stall_src = 0;
    int         stall_at  = 0;

    bit         tx_busy = 1'b0;
    int         tx_cnt  = 0;
    bit         inject_done = 1'b0;
    int         stray_starts = 0;
    int         ready_cnt [NR] = '{0, 0, 0, 0};
    logic [7:0] log_q [$];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic load(input int s, input int k, input logic [7:0] b, input logic l);
        src_b[s][k] = b;
        src_l[s][k] = l;
    endtask

    task automatic start_src(input int s, input int n);
        src_ptr[s] = 0;
        src_len[s] = n;
    endtask

    task automatic clear_stats();
        log_q.delete();
        for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
            check($sformatf("%s[%0d]", tag, k), log_q[k], exp_q[k]);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        bit drained;
        n = 0;
        forever begin
            @(negedge clk);
            drained = 1'b1;
            for (int i = 0; i < NR; i++)
                if (src_en[i] && src_ptr[i] < src_len[i]) drained = 1'b0;
            if (drained && !busy && !tx_busy) break;
            n++;
            if (n > 3000) begin
                check({tag, "_timeout"}, n, 0);
                break;
            end
        end
    endtask

    task automatic wait_ptr(input string tag, input int s, input int v);
        int n;
        n = 0;
        while (src_ptr[s] != v) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                check({tag, "_timeout"}, n, 0);
                break;
            end
        end
    endtask

    // Source and transmitter models: sample at negedge, drive just after posedge.
    initial begin
        logic [NR-1:0] s_ready;
        forever begin
            @(negedge clk);
            s_ready = req_ready;
            if (tx_start) begin
                if (tx_busy) stray_starts++;
                log_q.push_back(tx_data);
                tx_busy = 1'b1;
                tx_cnt  = TX_LAT;
            end
            for (int i = 0; i < NR; i++) if (s_ready[i]) ready_cnt[i]++;
            @(posedge clk);
            #1;
            tx_done     = inject_done;
            inject_done = 1'b0;
            if (tx_busy) begin
                if (tx_cnt == 0) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                end else begin
                    tx_cnt--;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (s_ready[i]) src_ptr[i]++;
                req_valid[i] = src_en[i] && (src_ptr[i] < src_len[i]) &&
                               !(stall_on && i == stall_src && src_ptr[i] == stall_at);
                req_data[8*i +: 8] = (src_ptr[i] < 16) ? src_b[i][src_ptr[i]] : 8'h00;
                req_last[i] = (src_ptr[i] < 16) ? src_l[i][src_ptr[i]] : 1'b0;
            end
        end
    end

    initial begin
        int bad_start;
        int bad_grant;

        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;

        // Two sources, two packets each: strict alternation with pointer wrap.
        clear_stats();
        load(0, 0, 8'h01, 1'b0); load(0, 1, 8'h02, 1'b1);
        load(0, 2, 8'h03, 1'b0); load(0, 3, 8'h04, 1'b1);
        load(3, 0, 8'h31, 1'b1); load(3, 1, 8'h32, 1'b1);
        start_src(0, 4); start_src(3, 2);
        src_en = 4'b1001;
        wait_done("rr03");
        exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA3, 8'h31, 8'hA0, 8'h03, 8'h04, 8'hA3, 8'h32};
        check_log("rr03");
        src_en = '0;

        // Single source, three bytes.
        clear_stats();
        load(0, 0, 8'h11, 1'b0); load(0, 1, 8'h22, 1'b0); load(0, 2, 8'h33, 1'b1);
        start_src(0, 3);
        src_en = 4'b0001;
        wait_done("single");
        exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
        check_log("single");
        check("single_ready", ready_cnt[0], 3);
        check("single_grant", grant, 0);
        check("single_ovf", overflow, 0);
        src_en = '0;

        // Sources 1 and 2 together: whole packets, no interleave.
        clear_stats();
        load(1, 0, 8'h51, 1'b0); load(1, 1, 8'h52, 1'b1);
        load(2, 0, 8'h61, 1'b0); load(2, 1, 8'h62, 1'b1);
        start_src(1, 2); start_src(2, 2);
        src_en = 4'b0110;
        wait_done("pair");
        exp_q = '{8'hA1, 8'h51, 8'h52, 8'hA2, 8'h61, 8'h62};
        check_log("pair");
        check("pair_ready1", ready_cnt[1], 2);
        check("pair_ready0", ready_cnt[0], 0);
        src_en = '0;

        // Length limit of 4: forced release, sticky overflow, re-header.
        clear_stats();
        for (int k = 0; k < 6; k++) load(2, k, 8'h71 + 8'(k), 1'b0);
        load(2, 6, 8'h77, 1'b1);
        start_src(2, 7);
        src_en = 4'b0100;
        wait_done("maxlen");
        exp_q = '{8'hA2, 8'h71, 8'h72, 8'h73, 8'h74, 8'hA2, 8'h75, 8'h76, 8'h77};
        check_log("maxlen");
        check("maxlen_ovf", overflow, 1);
        check("maxlen_ready", ready_cnt[2], 7);
        src_en = '0;

        // Mid-packet stall of 50 cycles.
        clear_stats();
        load(1, 0, 8'h81, 1'b0); load(1, 1, 8'h82, 1'b0); load(1, 2, 8'h83, 1'b1);
        stall_src = 1; stall_at = 1; stall_on = 1'b1;
        start_src(1, 3);
        src_en = 4'b0010;
        wait_ptr("stall", 1, 1);
        bad_start = 0;
        bad_grant = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start) bad_start++;
            if (grant != 4'b0010) bad_grant++;
        end
        check("stall_start", bad_start, 0);
        check("stall_grant", bad_grant, 0);
        check("stall_busy", busy, 1);
        stall_on = 1'b0;
        wait_done("stall");
        exp_q = '{8'hA1, 8'h81, 8'h82, 8'h83};
        check_log("stall");
        check("stall_grant_end", grant, 0);
        src_en = '0;

        // Asynchronous reset while a data byte is in flight.
        clear_stats();
        load(3, 0, 8'h91, 1'b0); load(3, 1, 8'h92, 1'b0); load(3, 2, 8'h93, 1'b1);
        start_src(3, 3);
        src_en = 4'b1000;
        wait_ptr("arst", 3, 1);
        check("arst_pre_grant", grant, 4'b1000);
        #2;
        rst = 1'b1;
        tx_busy = 1'b0;
        src_en = '0;
        #1;
        check("arst_grant", grant, 0);
        check("arst_start", tx_start, 0);
        check("arst_busy", busy, 0);
        check("arst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        inject_done = 1'b1;
        bad_start = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_start || busy) bad_start++;
        end
        check("stray_done", bad_start, 0);
        load(3, 0, 8'hC1, 1'b0); load(3, 1, 8'hC2, 1'b1);
        start_src(3, 2);
        src_en = 4'b1000;
        wait_done("restart");
        exp_q = '{8'hA3, 8'hC1, 8'hC2};
        check_log("restart");
        check("restart_grant", grant, 0);
        check("tx_overlap", stray_starts, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
